lisa_qspi_arb: RTL and testbench



---
 rtl/lisa_qspi_arb.sv | 216 +++++++++++++++++++++
 tb/tb_lisa_qspi_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lisa_qspi_arb.sv
// Three-port arbiter/sequencer for the LISA QSPI controller (inst/data/debug).
// Optional inst ageing: define LISA_QSPI_ARB_AGE_EN.
module lisa_qspi_arb #(
   parameter int INST_BURST = 4,
   parameter int AGE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [24:0] i_addr,
   output logic        i_ack,
   output logic        i_rvalid,
   output logic        i_done,
   input  logic        d_req,
   input  logic [24:0] d_addr,
   input  logic [15:0] d_wdata,
   input  logic [1:0]  d_wstrb,
   output logic        d_ack,
   output logic        d_rvalid,
   output logic        d_done,
   input  logic        g_req,
   input  logic [24:0] g_addr,
   input  logic [15:0] g_wdata,
   input  logic [1:0]  g_wstrb,
   input  logic [3:0]  g_len,
   output logic        g_ack,
   output logic        g_rvalid,
   output logic        g_done,
   output logic [15:0] rdata,
   output logic        m_valid,
   output logic [23:0] m_addr,
   output logic [15:0] m_wdata,
   output logic [1:0]  m_wstrb,
   output logic [3:0]  m_xfer_len,
   output logic [1:0]  m_ce_ctrl,
   input  logic        m_ready,
   input  logic        m_xfer_done,
   input  logic [15:0] m_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_I,
      GNT_D,
      GNT_G
   } gnt_t;

   state_t      state;
   gnt_t        gnt;
   gnt_t        win;
   logic        rdy_q;
   logic [3:0]  cnt;
   logic        inst_first;
   logic        grant_fire;
   logic        rise;
   logic        last_word;
   logic [24:0] win_addr;
   logic [15:0] win_wdata;
   logic [1:0]  win_wstrb;
   logic [3:0]  win_len;
   logic [3:0]  g_len_eff;

`ifdef LISA_QSPI_ARB_AGE_EN
   logic [3:0] age;

   // Counts non-inst grants issued while inst is left waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= 4'd0;
      end else if (!i_req) begin
         age <= 4'd0;
      end else if (grant_fire) begin
         if (win == GNT_I) begin
            age <= 4'd0;
         end else if (age != 4'hF) begin
            age <= age + 4'd1;
         end
      end
   end

   assign inst_first = i_req && (age >= 4'(AGE_LIMIT));
`else
   logic unused_age;

   assign unused_age = (AGE_LIMIT > 15);
   assign inst_first = 1'b0;
`endif

   // Debug writes are single-word; a zero length still moves one word.
   assign g_len_eff = ((g_wstrb != 2'b00) || (g_len == 4'd0))
                      ? 4'd1 : g_len;

   always_comb begin
      win = GNT_NONE;
      if (g_req) begin
         win = GNT_G;
      end else if (inst_first) begin
         win = GNT_I;
      end else if (d_req) begin
         win = GNT_D;
      end else if (i_req) begin
         win = GNT_I;
      end
   end

   always_comb begin
      win_addr  = i_addr;
      win_wdata = 16'h0000;
      win_wstrb = 2'b00;
      win_len   = 4'(INST_BURST);
      case (win)
         GNT_D: begin
            win_addr  = d_addr;
            win_wdata = d_wdata;
            win_wstrb = d_wstrb;
            win_len   = 4'd1;
         end
         GNT_G: begin
            win_addr  = g_addr;
            win_wdata = g_wdata;
            win_wstrb = g_wstrb;
            win_len   = g_len_eff;
         end
         default: ;
      endcase
   end

   assign grant_fire = (state == IDLE) && !m_ready && (win != GNT_NONE);
   assign rise       = m_ready && !rdy_q;
   assign last_word  = (cnt == (m_xfer_len - 4'd1)) || m_xfer_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= GNT_NONE;
         rdy_q      <= 1'b0;
         cnt        <= 4'd0;
         i_ack      <= 1'b0;
         i_rvalid   <= 1'b0;
         i_done     <= 1'b0;
         d_ack      <= 1'b0;
         d_rvalid   <= 1'b0;
         d_done     <= 1'b0;
         g_ack      <= 1'b0;
         g_rvalid   <= 1'b0;
         g_done     <= 1'b0;
         rdata      <= 16'h0000;
         m_valid    <= 1'b0;
         m_addr     <= 24'h000000;
         m_wdata    <= 16'h0000;
         m_wstrb    <= 2'b00;
         m_xfer_len <= 4'd0;
         m_ce_ctrl  <= 2'b00;
      end else begin
         rdy_q    <= m_ready;
         i_ack    <= 1'b0;
         d_ack    <= 1'b0;
         g_ack    <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         g_rvalid <= 1'b0;
         i_done   <= 1'b0;
         d_done   <= 1'b0;
         g_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_fire) begin
                  gnt        <= win;
                  cnt        <= 4'd0;
                  m_valid    <= 1'b1;
                  m_addr     <= win_addr[23:0];
                  m_wdata    <= win_wdata;
                  m_wstrb    <= win_wstrb;
                  m_xfer_len <= win_len;
                  m_ce_ctrl  <= win_addr[24] ? 2'b10 : 2'b01;
                  i_ack      <= (win == GNT_I);
                  d_ack      <= (win == GNT_D);
                  g_ack      <= (win == GNT_G);
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (rise) begin
                  rdata    <= m_rdata;
                  cnt      <= cnt + 4'd1;
                  i_rvalid <= (gnt == GNT_I);
                  d_rvalid <= (gnt == GNT_D);
                  g_rvalid <= (gnt == GNT_G);
                  if (last_word) begin
                     i_done  <= (gnt == GNT_I);
                     d_done  <= (gnt == GNT_D);
                     g_done  <= (gnt == GNT_G);
                     m_valid <= 1'b0;
                     state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Controller must clear ready before the next valid.
               if (!m_ready) begin
                  gnt   <= GNT_NONE;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lisa_qspi_arb.sv
// Directed bench for lisa_qspi_arb with a scoreboard of expected read words.
// Covers both builds of LISA_QSPI_ARB_AGE_EN.
module tb_lisa_qspi_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [24:0] i_addr;
   logic        i_ack, i_rvalid, i_done;
   logic        d_req;
   logic [24:0] d_addr;
   logic [15:0] d_wdata;
   logic [1:0]  d_wstrb;
   logic        d_ack, d_rvalid, d_done;
   logic        g_req;
   logic [24:0] g_addr;
   logic [15:0] g_wdata;
   logic [1:0]  g_wstrb;
   logic [3:0]  g_len;
   logic        g_ack, g_rvalid, g_done;
   logic [15:0] rdata;
   logic        m_valid;
   logic [23:0] m_addr;
   logic [15:0] m_wdata;
   logic [1:0]  m_wstrb;
   logic [3:0]  m_xfer_len;
   logic [1:0]  m_ce_ctrl;
   logic        m_ready;
   logic        m_xfer_done;
   logic [15:0] m_rdata;
   logic [73:0] all_out;

   typedef struct {
      int          port;
      logic [15:0] data;
      bit          last;
      bit          chkd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   assign all_out = {i_ack, i_rvalid, i_done, d_ack, d_rvalid, d_done,
                     g_ack, g_rvalid, g_done, rdata, m_valid, m_addr,
                     m_wdata, m_wstrb, m_xfer_len, m_ce_ctrl};

   lisa_qspi_arb #(
      .INST_BURST(4),
      .AGE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_ack      (i_ack),
      .i_rvalid   (i_rvalid),
      .i_done     (i_done),
      .d_req      (d_req),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_wstrb    (d_wstrb),
      .d_ack      (d_ack),
      .d_rvalid   (d_rvalid),
      .d_done     (d_done),
      .g_req      (g_req),
      .g_addr     (g_addr),
      .g_wdata    (g_wdata),
      .g_wstrb    (g_wstrb),
      .g_len      (g_len),
      .g_ack      (g_ack),
      .g_rvalid   (g_rvalid),
      .g_done     (g_done),
      .rdata      (rdata),
      .m_valid    (m_valid),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .m_xfer_len (m_xfer_len),
      .m_ce_ctrl  (m_ce_ctrl),
      .m_ready    (m_ready),
      .m_xfer_done(m_xfer_done),
      .m_rdata    (m_rdata)
   );

   task automatic chk(input string tag, input logic [79:0] obs,
                      input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and score any returned word.
   task automatic tick();
      logic [2:0] rv;
      logic [2:0] dn;
      exp_t       e;
      @(negedge clk);
      rv = {g_rvalid, d_rvalid, i_rvalid};
      dn = {g_done, d_done, i_done};
      if (rv != 3'b000) begin
         chk("sb_nonempty", 80'(sb.size() != 0), 80'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rvalid_port", 80'(rv), 80'(1) << e.port);
            chk("done_flag", 80'(dn), e.last ? (80'(1) << e.port) : 80'(0));
            if (e.chkd) chk("rdata", 80'(rdata), 80'(e.data));
         end
      end else if (dn != 3'b000) begin
         chk("done_without_rvalid", 80'(dn), 80'(0));
      end
   endtask

   task automatic grant(input int port, input logic [23:0] ea,
                        input logic [1:0] ece, input logic [3:0] elen,
                        input logic [1:0] ews, input logic [15:0] ewd,
                        input bit hold);
      int n;
      n = 0;
      while (m_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("grant_valid", 80'(m_valid), 80'(1));
      chk("ack_port", 80'({g_ack, d_ack, i_ack}), 80'(1) << port);
      chk("m_addr", 80'(m_addr), 80'(ea));
      chk("m_ce_ctrl", 80'(m_ce_ctrl), 80'(ece));
      chk("m_xfer_len", 80'(m_xfer_len), 80'(elen));
      chk("m_wstrb", 80'(m_wstrb), 80'(ews));
      chk("m_wdata", 80'(m_wdata), 80'(ewd));
      if (!hold) begin
         case (port)
            0: i_req = 1'b0;
            1: d_req = 1'b0;
            default: g_req = 1'b0;
         endcase
      end
   endtask

   // Controller model: one ready pulse per word, xfer_done with the last.
   task automatic serve(input int port, input int n, input logic [15:0] base,
                        input logic [15:0] step, input bit chkd);
      logic [15:0] v;
      bit          last;
      for (int k = 0; k < n; k++) begin
         last = (k == n - 1);
         v = base + 16'(step * 16'(k));
         m_rdata = v;
         m_ready = 1'b1;
         m_xfer_done = last;
         sb.push_back('{port, v, last, chkd});
         tick();
         tick();
         if (!last) begin
            m_ready = 1'b0;
            tick();
         end
      end
      chk("drain_valid_low", 80'({m_valid, m_ready}), 80'(2'b01));
      tick();
      chk("drain_hold", 80'(m_valid), 80'(0));
      m_ready = 1'b0;
      m_xfer_done = 1'b0;
      tick();
      chk("sb_drained", 80'(sb.size()), 80'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      g_req = 1'b0; g_addr = '0; g_wdata = '0; g_wstrb = '0; g_len = '0;
      m_ready = 1'b0; m_xfer_done = 1'b0; m_rdata = '0;
      tick();
      tick();
      chk("reset_outputs", 80'(all_out), 80'(0));
      rst_n = 1'b1;
      tick();

      // single inst burst
      i_addr = 25'h0000100;
      i_req = 1'b1;
      grant(0, 24'h000100, 2'b01, 4'd4, 2'b00, 16'h0000, 1'b0);
      serve(0, 4, 16'h1111, 16'h1111, 1'b1);

      // data write to chip 1
      d_addr = 25'h1000010; d_wstrb = 2'b10; d_wdata = 16'hAB00;
      d_req = 1'b1;
      grant(1, 24'h000010, 2'b10, 4'd1, 2'b10, 16'hAB00, 1'b0);
      serve(1, 1, 16'h0000, 16'h0000, 1'b0);

      // all three requesters at once
      g_addr = 25'h0000400; g_wstrb = 2'b00; g_len = 4'd2;
      g_wdata = 16'h2468;
      d_addr = 25'h1000020; d_wstrb = 2'b00; d_wdata = 16'h1357;
      i_addr = 25'h0000500;
      g_req = 1'b1; d_req = 1'b1; i_req = 1'b1;
      grant(2, 24'h000400, 2'b01, 4'd2, 2'b00, 16'h2468, 1'b0);
      serve(2, 2, 16'hA001, 16'h0001, 1'b1);
      grant(1, 24'h000020, 2'b10, 4'd1, 2'b00, 16'h1357, 1'b0);
      serve(1, 1, 16'hD00D, 16'h0000, 1'b1);
      grant(0, 24'h000500, 2'b01, 4'd4, 2'b00, 16'h0000, 1'b0);
      serve(0, 4, 16'h0100, 16'h0100, 1'b1);

      // debug write forces length 1, debug read with zero length
      g_addr = 25'h1000040; g_wstrb = 2'b11; g_len = 4'd5;
      g_wdata = 16'hBEEF; g_req = 1'b1;
      grant(2, 24'h000040, 2'b10, 4'd1, 2'b11, 16'hBEEF, 1'b0);
      serve(2, 1, 16'h0000, 16'h0000, 1'b0);
      g_addr = 25'h0000050; g_wstrb = 2'b00; g_len = 4'd0; g_req = 1'b1;
      grant(2, 24'h000050, 2'b01, 4'd1, 2'b00, 16'hBEEF, 1'b0);
      serve(2, 1, 16'hC0DE, 16'h0000, 1'b1);

      // reset during the second word of an inst burst
      i_addr = 25'h0000300; i_req = 1'b1;
      grant(0, 24'h000300, 2'b01, 4'd4, 2'b00, 16'h0000, 1'b0);
      m_rdata = 16'h1234; m_ready = 1'b1;
      sb.push_back('{0, 16'h1234, 1'b0, 1'b1});
      tick();
      tick();
      m_ready = 1'b0;
      tick();
      m_rdata = 16'h5678; m_ready = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", 80'(all_out), 80'(0));
      m_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      d_addr = 25'h0000200; d_wstrb = 2'b00; d_wdata = 16'h0000;
      d_req = 1'b1;
      grant(1, 24'h000200, 2'b01, 4'd1, 2'b00, 16'h0000, 1'b0);
      serve(1, 1, 16'h5A5A, 16'h0000, 1'b1);

      // data held continuously while inst waits
      d_addr = 25'h0000060; i_addr = 25'h0000700;
      d_req = 1'b1; i_req = 1'b1;
`ifdef LISA_QSPI_ARB_AGE_EN
      for (int k = 0; k < 4; k++) begin
         grant(1, 24'h000060, 2'b01, 4'd1, 2'b00, 16'h0000, 1'b1);
         serve(1, 1, 16'h6000 + 16'(k), 16'h0000, 1'b1);
      end
      grant(0, 24'h000700, 2'b01, 4'd4, 2'b00, 16'h0000, 1'b0);
      serve(0, 4, 16'h7001, 16'h0001, 1'b1);
      grant(1, 24'h000060, 2'b01, 4'd1, 2'b00, 16'h0000, 1'b0);
      serve(1, 1, 16'h6100, 16'h0000, 1'b1);
`else
      for (int k = 0; k < 5; k++) begin
         grant(1, 24'h000060, 2'b01, 4'd1, 2'b00, 16'h0000, k != 4);
         serve(1, 1, 16'h6000 + 16'(k), 16'h0000, 1'b1);
      end
      grant(0, 24'h000700, 2'b01, 4'd4, 2'b00, 16'h0000, 1'b0);
      serve(0, 4, 16'h7001, 16'h0001, 1'b1);
`endif

      tick();
      chk("idle_valid_low", 80'(m_valid), 80'(0));
      chk("sb_empty_end", 80'(sb.size()), 80'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
